multicycle_controller: RTL and testbench

Main control FSM for the multicycle RV32I core. It sequences the shared datapath (PC, instruction register, immediate extender, ALU, ALUOut, register file and unified memory) through fetch, decode, execute, memory and writeback. It decodes the opcode into `ImmSrc`, ALU and mux selects and write enables, and stalls on a memory-ready handshake. It sits beside the decode-stage immediate extender and drives its `ImmSrc` input.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller_alu_decoder.sv | 36 +++
 rtl/multicycle_controller.sv | 156 +++++++++++++++
 tb/tb_multicycle_controller.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle RV32I control path.
// Holds the controller state enum, supported opcodes, ImmSrc / ALUControl /
// ALUOp encodings and datapath mux selects. The immediate extender imports
// the IMM_* encodings from here so both sides agree on ImmSrc.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Immediate format selected purely from the opcode; R-type and unknown
    // opcodes carry no immediate.
    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BRANCH:   imm_src = IMM_B;
            OP_LUI:      imm_src = IMM_U;
            OP_JAL:      imm_src = IMM_J;
            default:     imm_src = IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control bundle between the controller and the
// shared datapath.
//   master (controller): receives instruction fields, Zero and MemReady;
//                        drives ImmSrc, ALU/mux selects and write enables.
//   slave  (datapath):   the mirror image.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic [2:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       IllegalInstr;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output ImmSrc, ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
               IRWrite, PCWrite, RegWrite, MemWrite, IllegalInstr
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  ImmSrc, ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
               IRWrite, PCWrite, RegWrite, MemWrite, IllegalInstr
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: combinational ALUControl decode.
//   alu_op      in  2  00 add, 01 sub, 10 decode from funct3
//   funct3      in  3  Instr[14:12]
//   op5         in  1  op[5], distinguishes R-type from I-ALU
//   funct7b5    in  1  Instr[30]
//   alu_control out 3  ALU operation select
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type sub has Instr[30] set; addi with a
                    // negative immediate also has it, hence the op5 gate.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback over the shared datapath.
//   clk  in  core clock
//   rst  in  synchronous active-high reset, loads FETCH
//   bus  master modport of multicycle_controller_if (instruction fields,
//        Zero, MemReady in; ImmSrc, ALU/mux selects, write enables out)
// Outputs are decoded from the registered state; IRWrite, PCWrite and
// IllegalInstr also follow MemReady/Zero/op in the same cycle.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);

    // Width is informational only; flag misuse at elaboration.
    if (DATA_WIDTH != 32) begin : g_width_check
        $error("multicycle_controller supports DATA_WIDTH = 32 only");
    end

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_update, branch, taken;
    logic       ir_write, reg_write, mem_write, illegal;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        alu_op        = ALUOP_ADD;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RD2;
        bus.ResultSrc = RES_ALUOUT;
        bus.AdrSrc    = 1'b0;
        ir_write      = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURES;
                ir_write      = bus.MemReady;
                pc_update     = bus.MemReady;
                if (bus.MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut latches OldPC + imm: the branch target.
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BRANCH:    state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_LUI:       state_d = S_LUI;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
                state_d     = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                if (bus.MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                reg_write     = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                mem_write  = 1'b1;
                if (bus.MemReady) state_d = S_FETCH;
            end
            S_EXECR: begin
                bus.ALUSrcA = SRCA_RD1;
                alu_op      = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
                alu_op      = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA = SRCA_RD1;
                alu_op      = ALUOP_SUB;
                branch      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                // PC <- branch target held in ALUOut; ALU computes OldPC+4
                // which ALUWB then writes to rd.
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                pc_update   = 1'b1;
                state_d     = S_ALUWB;
            end
            S_LUI: begin
                bus.ALUSrcA = SRCA_ZERO;
                bus.ALUSrcB = SRCB_IMM;
                state_d     = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // beq/bne only; other funct3 values never redirect the PC.
    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = ~bus.Zero;
            default: taken = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .op5         (bus.op[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (bus.ALUControl)
    );

    assign bus.ImmSrc = imm_src(bus.op);

    // Write enables are held off while in reset so an abandoned instruction
    // cannot commit anything.
    assign bus.IRWrite      = ~rst & ir_write;
    assign bus.PCWrite      = ~rst & (pc_update | (branch & taken));
    assign bus.RegWrite     = ~rst & reg_write;
    assign bus.MemWrite     = ~rst & mem_write;
    assign bus.IllegalInstr = ~rst & illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver applies one cycle of
// inputs and queues the hand-computed outputs for that cycle; the monitor
// pops and compares on every falling edge.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] LU  = 7'b0110111;
    localparam logic [6:0] ILL = 7'b1110011;

    // en = {IRWrite, PCWrite, RegWrite, MemWrite, IllegalInstr}
    typedef struct packed {
        logic [2:0] imm;
        logic [2:0] alu;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic       adr;
        logic [4:0] en;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t  exp_q[$];
    string nm_q[$];

    always #5 clk = ~clk;

    multicycle_controller_if bus_if ();

    multicycle_controller #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic step(input string nm, input logic r, input logic [6:0] o,
                        input logic [2:0] f3, input logic f7, input logic z,
                        input logic mr, input logic [2:0] imm,
                        input logic [2:0] alu, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [1:0] rs,
                        input logic adr, input logic [4:0] en);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus_if.op       = o;
        bus_if.funct3   = f3;
        bus_if.funct7b5 = f7;
        bus_if.Zero     = z;
        bus_if.MemReady = mr;
        e.imm = imm; e.alu = alu; e.sa = sa; e.sb = sb;
        e.rs = rs; e.adr = adr; e.en = en;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            a.imm = bus_if.ImmSrc;     a.alu = bus_if.ALUControl;
            a.sa  = bus_if.ALUSrcA;    a.sb  = bus_if.ALUSrcB;
            a.rs  = bus_if.ResultSrc;  a.adr = bus_if.AdrSrc;
            a.en  = {bus_if.IRWrite, bus_if.PCWrite, bus_if.RegWrite,
                     bus_if.MemWrite, bus_if.IllegalInstr};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got imm=%b alu=%b a=%b b=%b res=%b adr=%b en=%b, want imm=%b alu=%b a=%b b=%b res=%b adr=%b en=%b",
                         nm, a.imm, a.alu, a.sa, a.sb, a.rs, a.adr, a.en,
                         e.imm, e.alu, e.sa, e.sb, e.rs, e.adr, e.en);
            end
        end
    end

    initial begin
        bus_if.op = RT; bus_if.funct3 = 3'b000; bus_if.funct7b5 = 1'b0;
        bus_if.Zero = 1'b0; bus_if.MemReady = 1'b1;
        repeat (2) @(posedge clk);

        // Reset held: FETCH selects, enables forced off despite MemReady.
        step("rst_fetch", 1, RT, 3'b000, 1, 0, 1, 3'b000, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b00000);

        // R-type sub
        step("sub_fetch",  0, RT, 3'b000, 1, 0, 1, 3'b000, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("sub_decode", 0, RT, 3'b000, 1, 0, 1, 3'b000, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("sub_execr",  0, RT, 3'b000, 1, 0, 1, 3'b000, 3'b001, 2'b10, 2'b00, 2'b00, 0, 5'b00000);
        step("sub_aluwb",  0, RT, 3'b000, 1, 0, 1, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 0, 5'b00100);

        // R-type and
        step("and_fetch",  0, RT, 3'b111, 0, 0, 1, 3'b000, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("and_decode", 0, RT, 3'b111, 0, 0, 1, 3'b000, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("and_execr",  0, RT, 3'b111, 0, 0, 1, 3'b000, 3'b010, 2'b10, 2'b00, 2'b00, 0, 5'b00000);
        step("and_aluwb",  0, RT, 3'b111, 0, 0, 1, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 0, 5'b00100);

        // lw: 2 fetch waits, 3 memread waits -> 10 cycles
        step("lw_fetch_w1", 0, LW, 3'b010, 0, 0, 0, 3'b001, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b00000);
        step("lw_fetch_w2", 0, LW, 3'b010, 0, 0, 0, 3'b001, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b00000);
        step("lw_fetch",    0, LW, 3'b010, 0, 0, 1, 3'b001, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("lw_decode",   0, LW, 3'b010, 0, 0, 1, 3'b001, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("lw_memadr",   0, LW, 3'b010, 0, 0, 1, 3'b001, 3'b000, 2'b10, 2'b01, 2'b00, 0, 5'b00000);
        step("lw_mrd_w1",   0, LW, 3'b010, 0, 0, 0, 3'b001, 3'b000, 2'b00, 2'b00, 2'b00, 1, 5'b00000);
        step("lw_mrd_w2",   0, LW, 3'b010, 0, 0, 0, 3'b001, 3'b000, 2'b00, 2'b00, 2'b00, 1, 5'b00000);
        step("lw_mrd_w3",   0, LW, 3'b010, 0, 0, 0, 3'b001, 3'b000, 2'b00, 2'b00, 2'b00, 1, 5'b00000);
        step("lw_mrd",      0, LW, 3'b010, 0, 0, 1, 3'b001, 3'b000, 2'b00, 2'b00, 2'b00, 1, 5'b00000);
        step("lw_memwb",    0, LW, 3'b010, 0, 0, 1, 3'b001, 3'b000, 2'b00, 2'b00, 2'b01, 0, 5'b00100);

        // beq taken; MemReady low in DECODE/BRANCH must be ignored
        step("beq1_fetch",  0, BR, 3'b000, 0, 1, 1, 3'b011, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("beq1_decode", 0, BR, 3'b000, 0, 1, 0, 3'b011, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("beq1_branch", 0, BR, 3'b000, 0, 1, 0, 3'b011, 3'b001, 2'b10, 2'b00, 2'b00, 0, 5'b01000);
        // beq not taken
        step("beq0_fetch",  0, BR, 3'b000, 0, 0, 1, 3'b011, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("beq0_decode", 0, BR, 3'b000, 0, 0, 1, 3'b011, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("beq0_branch", 0, BR, 3'b000, 0, 0, 1, 3'b011, 3'b001, 2'b10, 2'b00, 2'b00, 0, 5'b00000);
        // bne Zero=1: not taken
        step("bne1_fetch",  0, BR, 3'b001, 0, 1, 1, 3'b011, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("bne1_decode", 0, BR, 3'b001, 0, 1, 1, 3'b011, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("bne1_branch", 0, BR, 3'b001, 0, 1, 1, 3'b011, 3'b001, 2'b10, 2'b00, 2'b00, 0, 5'b00000);
        // bne Zero=0: taken
        step("bne0_fetch",  0, BR, 3'b001, 0, 0, 1, 3'b011, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("bne0_decode", 0, BR, 3'b001, 0, 0, 1, 3'b011, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("bne0_branch", 0, BR, 3'b001, 0, 0, 1, 3'b011, 3'b001, 2'b10, 2'b00, 2'b00, 0, 5'b01000);

        // sw with one MEMWRITE wait
        step("sw_fetch",   0, SW, 3'b010, 0, 0, 1, 3'b010, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("sw_decode",  0, SW, 3'b010, 0, 0, 1, 3'b010, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("sw_memadr",  0, SW, 3'b010, 0, 0, 1, 3'b010, 3'b000, 2'b10, 2'b01, 2'b00, 0, 5'b00000);
        step("sw_mwr_w1",  0, SW, 3'b010, 0, 0, 0, 3'b010, 3'b000, 2'b00, 2'b00, 2'b00, 1, 5'b00010);
        step("sw_mwr",     0, SW, 3'b010, 0, 0, 1, 3'b010, 3'b000, 2'b00, 2'b00, 2'b00, 1, 5'b00010);

        // jal
        step("jal_fetch",  0, JL, 3'b000, 0, 0, 1, 3'b101, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("jal_decode", 0, JL, 3'b000, 0, 0, 1, 3'b101, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("jal_jal",    0, JL, 3'b000, 0, 0, 1, 3'b101, 3'b000, 2'b01, 2'b10, 2'b00, 0, 5'b01000);
        step("jal_aluwb",  0, JL, 3'b000, 0, 0, 1, 3'b101, 3'b000, 2'b00, 2'b00, 2'b00, 0, 5'b00100);

        // addi with Instr[30] set must still add (op[5]=0)
        step("addi_fetch",  0, IT, 3'b000, 1, 0, 1, 3'b001, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("addi_decode", 0, IT, 3'b000, 1, 0, 1, 3'b001, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("addi_execi",  0, IT, 3'b000, 1, 0, 1, 3'b001, 3'b000, 2'b10, 2'b01, 2'b00, 0, 5'b00000);
        step("addi_aluwb",  0, IT, 3'b000, 1, 0, 1, 3'b001, 3'b000, 2'b00, 2'b00, 2'b00, 0, 5'b00100);

        // slti
        step("slti_fetch",  0, IT, 3'b010, 0, 0, 1, 3'b001, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("slti_decode", 0, IT, 3'b010, 0, 0, 1, 3'b001, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("slti_execi",  0, IT, 3'b010, 0, 0, 1, 3'b001, 3'b101, 2'b10, 2'b01, 2'b00, 0, 5'b00000);
        step("slti_aluwb",  0, IT, 3'b010, 0, 0, 1, 3'b001, 3'b000, 2'b00, 2'b00, 2'b00, 0, 5'b00100);

        // lui
        step("lui_fetch",  0, LU, 3'b000, 0, 0, 1, 3'b100, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("lui_decode", 0, LU, 3'b000, 0, 0, 1, 3'b100, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("lui_lui",    0, LU, 3'b000, 0, 0, 1, 3'b100, 3'b000, 2'b11, 2'b01, 2'b00, 0, 5'b00000);
        step("lui_aluwb",  0, LU, 3'b000, 0, 0, 1, 3'b100, 3'b000, 2'b00, 2'b00, 2'b00, 0, 5'b00100);

        // illegal opcode: pulse in DECODE, then back to FETCH
        step("ill_fetch",  0, ILL, 3'b000, 0, 0, 1, 3'b000, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("ill_decode", 0, ILL, 3'b000, 0, 0, 1, 3'b000, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00001);
        step("ill_refetch",0, ILL, 3'b000, 0, 0, 0, 3'b000, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b00000);

        // reset while in MEMREAD
        step("rlw_fetch",  0, LW, 3'b010, 0, 0, 1, 3'b001, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b11000);
        step("rlw_decode", 0, LW, 3'b010, 0, 0, 1, 3'b001, 3'b000, 2'b01, 2'b01, 2'b00, 0, 5'b00000);
        step("rlw_memadr", 0, LW, 3'b010, 0, 0, 1, 3'b001, 3'b000, 2'b10, 2'b01, 2'b00, 0, 5'b00000);
        step("rlw_mrd",    0, LW, 3'b010, 0, 0, 0, 3'b001, 3'b000, 2'b00, 2'b00, 2'b00, 1, 5'b00000);
        step("rlw_mrd_rst",1, LW, 3'b010, 0, 0, 1, 3'b001, 3'b000, 2'b00, 2'b00, 2'b00, 1, 5'b00000);
        step("rlw_fetch2", 0, LW, 3'b010, 0, 0, 0, 3'b001, 3'b000, 2'b00, 2'b10, 2'b10, 0, 5'b00000);

        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                n_fail++;
                $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
            end
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
